act_drain: RTL and testbench
============================

# act_drain

Output-side drain for the convolution pipeline. It accepts the wide per-pixel activation vector (NFMAPS channels of BITWIDTH bits, strobed by `valid` with no backpressure) and buffers it in a small FIFO. It serializes each vector into one BITWIDTH word per feature map over a valid/ready handshake, and marks the last word of each output frame. It is the reverse of the input buffer: it turns parallel layer output back into a serial stream for the host or memory writer.

## Interface

Parameters:
- `BITWIDTH`, 16: bits per activation word.
- `NFMAPS`, 6: feature maps per output pixel (vector = NFMAPS*BITWIDTH bits).
- `DEPTH`, 8: FIFO entries (full vectors); power of two.
- `AW`, 3: log2(DEPTH).
- `NPIX`, 784: output pixels per frame.
- `PW`, 10: pixel counter width, at least clog2(NPIX).
- `CW`, 3: channel index width, at least clog2(NFMAPS).

Ports:
- `clk`  in  1: clock, rising edge.
- `rstn`  in  1: asynchronous active-low reset.
- `valid`  in  1: `input_act` holds a new pixel vector this cycle.
- `flush`  in  1: synchronous frame abort/restart.
- `input_act`  in  NFMAPS*BITWIDTH: pixel vector; fmap k at bits [k*BITWIDTH +: BITWIDTH].
- `output_act`  out  BITWIDTH: current serialized word.
- `out_chan`  out  CW: fmap index of `output_act`.
- `out_valid`  out  1: `output_act` is valid.
- `out_ready`  in  1: consumer accepts the word when high together with `out_valid`.
- `out_last`  out  1: word is channel NFMAPS-1 of pixel NPIX-1 of the frame.
- `overflow`  out  1: sticky; a `valid` vector was dropped.

## Operation

- **Storage:** FIFO of DEPTH vectors plus one output holding register (vector + channel counter). Total capacity is DEPTH+1 pixels.
- **Write:** if `valid` and (FIFO not full, or a pop happens in the same cycle), write the vector.
  - Otherwise the vector is dropped and `overflow` is set.
  - `overflow` stays set until `flush` or reset.
- **Load:** the output register loads from the FIFO head (pop) when the FIFO is non-empty and either condition holds:
  - the register is idle (`out_valid`=0), or
  - the channel NFMAPS-1 word is handshaking this cycle.
- On load: `out_chan` is 0 and `out_valid` is 1.
- **Handshake:** on `out_valid && out_ready`:
  - if `out_chan` < NFMAPS-1, increment `out_chan`;
  - otherwise the pixel is done: load the next vector if one is available, else set `out_valid` to 0.
- **Output word:** `output_act` = held vector slice at `out_chan`. It is registered/muxed from registers only, with no combinational path from inputs.
- **Stability:** while `out_valid`=1 and `out_ready`=0, `output_act`, `out_chan` and `out_last` hold stable.
- **Frame counting:** the pixel counter increments when the last channel of a pixel handshakes. It wraps from NPIX-1 to 0.
- **`out_last`:** equals (`pix_cnt`==NPIX-1) && (`out_chan`==NFMAPS-1) && `out_valid`.
- **`flush`:** clears FIFO pointers, the output register, `out_valid`, `out_chan`, `pix_cnt` and `overflow`.
  - Flush has priority; a `valid` in the same cycle is discarded and does not set `overflow`.
- **FIFO bookkeeping:** an occupancy counter of AW+1 bits. Full means count==DEPTH; empty means count==0.

## Timing

- **Reset values:** all outputs 0 (`output_act`, `out_chan`, `out_valid`, `out_last`, `overflow`); FIFO empty; `pix_cnt`=0.
- **Latency:** `valid` sampled at edge E with the FIFO empty and the output idle:
  - written at E;
  - popped at E+1;
  - `out_valid`=1 in the cycle after edge E+1, i.e. 2 cycles after `valid`.
- **Throughput:** with `out_ready` held high, one word per cycle, NFMAPS cycles per pixel. There is no bubble between consecutive pixels when the FIFO is non-empty.
- **Full-FIFO write:** a write while full succeeds only if the pop happens in the same cycle.
- **Async reset mid-transfer:** all state clears immediately; no partial pixel is resumed after reset release.
- **`flush` mid-pixel:** the remaining channels are abandoned. `out_valid`=0 the cycle after the flush edge.

## Test plan

- **Single pixel:** one `valid` with fmaps 0..5 = 0x0001..0x0006, `out_ready`=1.
  - Expect `out_valid` 2 cycles later.
  - Expect words 0x0001..0x0006 on 6 consecutive cycles with `out_chan` 0..5.
  - Expect `out_last`=0.
- **Backpressure:** `out_ready` toggles 1,0,0,1 during a pixel. Words advance only on handshake; `output_act` and `out_chan` are stable while stalled; all 6 words are delivered in order.
- **Overflow:** `out_ready`=0, then 9 `valid` pulses (DEPTH+1) followed by a 10th.
  - Expect `overflow`=1 after the 10th; the first 9 pixels drain intact.
  - After `flush`, expect `overflow`=0.
- **Frame marker:** NPIX=4, NFMAPS=6, 5 pixels streamed.
  - `out_last`=1 only on word 24 (pixel 3, channel 5).
  - Pixel 4 starts a new frame with `out_last`=0.
- **Flush collisions:** `flush` asserted with `valid` in the same cycle, mid-pixel at `out_chan`=2. Expect `out_valid`=0 next cycle, FIFO empty, and no `overflow`.
- **Async reset mid-drain:** reset at `out_chan`=3 with 4 pixels queued. All outputs go to 0 immediately; after release, a new pixel drains from `out_chan` 0 with 2-cycle latency.

Source files
------------

// File: rtl/act_drain.sv
// act_drain: buffers parallel activation vectors in a FIFO and serializes them one fmap word per handshake.
// Ports: clk/rstn (async active-low); valid/input_act push a pixel vector; flush aborts the frame;
// output_act/out_chan/out_valid/out_last with out_ready form the serial stream; overflow is a sticky drop flag.
module act_drain #(
  parameter int BITWIDTH = 16,
  parameter int NFMAPS   = 6,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int NPIX     = 784,
  parameter int PW       = 10,
  parameter int CW       = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       valid,
  input  logic                       flush,
  input  logic [NFMAPS*BITWIDTH-1:0] input_act,
  output logic [BITWIDTH-1:0]        output_act,
  output logic [CW-1:0]              out_chan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       overflow
);
  localparam int VW = NFMAPS * BITWIDTH;
  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] hold;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [PW-1:0] pix_cnt;
  logic          last_chan, hs, pop, push;
  assign last_chan  = out_chan == CW'(NFMAPS - 1);
  assign hs         = out_valid && out_ready;
  // the head may move into the holding register when it is idle or its final word is leaving
  assign pop        = count != '0 && (!out_valid || (hs && last_chan));
  assign push       = valid && (count != (AW+1)'(DEPTH) || pop);
  assign output_act = hold[out_chan*BITWIDTH +: BITWIDTH];
  assign out_last   = out_valid && last_chan && pix_cnt == PW'(NPIX - 1);
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= input_act;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold      <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      pix_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (valid && !push) overflow <= 1'b1;
      if (pop) begin
        hold      <= mem[rd_ptr];
        out_chan  <= '0;
        out_valid <= 1'b1;
      end else if (hs) begin
        if (last_chan) out_valid <= 1'b0;
        else out_chan <= out_chan + 1'b1;
      end
      if (hs && last_chan) pix_cnt <= pix_cnt == PW'(NPIX - 1) ? '0 : pix_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_act_drain.sv
// tb_act_drain: randomized and directed checks of act_drain against a pixel-queue reference model.
module tb_act_drain;
  localparam int BW = 16, NF = 6, DEPTH = 8, AW = 3, NPIX = 4, PW = 2, CW = 3, VW = NF * BW;
  logic clk = 0, rstn = 0, valid = 0, flush = 0, out_ready = 0;
  logic [VW-1:0] input_act = '0;
  logic [BW-1:0] output_act;
  logic [CW-1:0] out_chan;
  logic out_valid, out_last, overflow;
  act_drain #(.BITWIDTH(BW), .NFMAPS(NF), .DEPTH(DEPTH), .AW(AW), .NPIX(NPIX), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .flush(flush), .input_act(input_act),
    .output_act(output_act), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [VW-1:0] q[$];
  bit act, ovf;
  int chan, pix;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    act = 0;
    chan = 0;
    pix = 0;
    ovf = 0;
  endtask
  task automatic compare();
    logic [VW-1:0] v;
    check("out_valid", out_valid, act);
    check("out_last", out_last, act && pix == NPIX - 1 && chan == NF - 1);
    check("overflow", overflow, ovf);
    if (act) begin
      v = q[0];
      check("output_act", output_act, v[chan*BW +: BW]);
      check("out_chan", out_chan, chan);
    end
  endtask
  task automatic check_zero(string tag);
    check({tag, "_act"}, output_act, 0);
    check({tag, "_chan"}, out_chan, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask
  // pending pixels live in q (head = pixel being serialized when act); capacity is DEPTH queued plus one active
  task automatic step(bit v, bit f, bit r, logic [VW-1:0] d);
    int fc;
    bit hs, done, pop, push;
    valid = v;
    flush = f;
    out_ready = r;
    input_act = d;
    if (f) model_reset();
    else begin
      fc = q.size() - int'(act);
      hs = act && r;
      done = hs && chan == NF - 1;
      pop = fc > 0 && (!act || done);
      push = v && (fc < DEPTH || pop);
      if (done) begin
        void'(q.pop_front());
        pix = (pix + 1) % NPIX;
      end
      if (hs && !done) chan++;
      if (pop) begin
        act = 1;
        chan = 0;
      end else if (done) act = 0;
      if (push) q.push_back(d);
      else if (v) ovf = 1;
    end
    @(negedge clk);
    compare();
  endtask
  function automatic logic [VW-1:0] mk(int base);
    logic [VW-1:0] d;
    for (int k = 0; k < NF; k++) d[k*BW +: BW] = BW'(base + k);
    return d;
  endfunction
  int widx, last_idx, last_cnt;
  initial begin
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    rstn = 1;
    // single pixel with 2-cycle latency
    step(1, 0, 1, mk(1));
    check("lat_e0", out_valid, 0);
    step(0, 0, 1, '0);
    check("lat_e1", out_valid, 1);
    check("first_word", output_act, 16'h0001);
    for (int i = 0; i < 7; i++) step(0, 0, 1, '0);
    // backpressure pattern inside a pixel
    step(1, 0, 0, mk(16'h100));
    step(0, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 0, (i % 4 == 0) || (i % 4 == 3), '0);
    check("bp_drained", out_valid, 0);
    // overflow: DEPTH+1 accepted, next one dropped
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, mk(16'h200 + 16 * i));
    check("ovf_before", overflow, 0);
    step(1, 0, 0, mk(16'h7000));
    check("ovf_after", overflow, 1);
    for (int i = 0; i < (DEPTH + 1) * NF + 3; i++) step(0, 0, 1, '0);
    check("ovf_drained", out_valid, 0);
    step(0, 1, 1, '0);
    check("ovf_flushed", overflow, 0);
    // frame marker across 5 pixels
    widx = 0;
    last_idx = -1;
    last_cnt = 0;
    for (int i = 0; i < 5 * NF + 8; i++) begin
      step(i < 5, 0, 1, mk(16'h300 + 16 * i));
      if (out_valid) begin
        if (out_last) begin
          last_cnt++;
          last_idx = widx;
        end
        widx++;
      end
    end
    check("frame_words", widx, 5 * NF);
    check("last_idx", last_idx, 23);
    check("last_cnt", last_cnt, 1);
    // flush colliding with valid mid-pixel
    step(1, 0, 1, mk(16'h400));
    step(1, 0, 1, mk(16'h410));
    for (int i = 0; i < 20 && !(out_valid && out_chan == 2); i++) step(0, 0, 1, '0);
    check("reach_chan2", out_chan, 2);
    step(1, 1, 1, mk(16'h420));
    check("flush_valid", out_valid, 0);
    check("flush_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    check("flush_empty", out_valid, 0);
    // async reset mid-drain
    for (int i = 0; i < 5; i++) step(1, 0, 0, mk(16'h500 + 16 * i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    check("reach_chan3", out_chan, 3);
    #2 rstn = 0;
    #1 check_zero("async");
    model_reset();
    @(negedge clk);
    rstn = 1;
    step(1, 0, 1, mk(16'h600));
    check("post_rst_e0", out_valid, 0);
    step(0, 0, 1, '0);
    check("post_rst_e1", out_valid, 1);
    check("post_rst_chan", out_chan, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(2, 0) == 0, $urandom_range(199, 0) == 0, $urandom_range(2, 0) != 0,
           {$urandom, $urandom, $urandom});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
